// File: rtl/lcd_pattern_gen_if.sv
// Video bus between the 800x480 timing generator and the pattern source.
// The timing side drives the i_* group; the pattern source drives the o_* group.
interface lcd_pattern_gen_if;
    logic        i_rgb_hs;
    logic        i_rgb_vs;
    logic        i_rgb_de;
    logic [10:0] i_rgb_x;
    logic [10:0] i_rgb_y;
    logic        o_rgb_hs;
    logic        o_rgb_vs;
    logic        o_rgb_de;
    logic [23:0] o_rgb_data;

    modport master (
        output i_rgb_hs, i_rgb_vs, i_rgb_de, i_rgb_x, i_rgb_y,
        input  o_rgb_hs, o_rgb_vs, o_rgb_de, o_rgb_data
    );

    modport slave (
        input  i_rgb_hs, i_rgb_vs, i_rgb_de, i_rgb_x, i_rgb_y,
        output o_rgb_hs, o_rgb_vs, o_rgb_de, o_rgb_data
    );
endinterface

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source for an 800x480 RGB LCD.
// Eight patterns selected by a debounced key; the selection is applied only at
// the start of vertical sync. Sync/DE are delayed 2 clocks to match the data.
module lcd_pattern_gen #(
    parameter int unsigned H_ACTIVE        = 800,
    parameter int unsigned V_ACTIVE        = 480,
    parameter logic        VS_POL          = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = 660000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned CHECKER_SHIFT   = 5,
    parameter logic [2:0]  INIT_MODE       = 3'd0
) (
    input  logic               i_rgb_clk,
    input  logic               i_rgb_rst_n,
    input  logic               i_key,
    lcd_pattern_gen_if.slave   rgb,
    output logic [2:0]         o_mode
);

    typedef enum logic [2:0] {
        PAT_BARS    = 3'd0,
        PAT_GRAY    = 3'd1,
        PAT_CHECKER = 3'd2,
        PAT_RED     = 3'd3,
        PAT_GREEN   = 3'd4,
        PAT_BLUE    = 3'd5,
        PAT_WHITE   = 3'd6,
        PAT_BORDER  = 3'd7
    } pattern_t;

    localparam int unsigned      BAR_W   = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [10:0]      X_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0]      Y_LAST  = 11'(V_ACTIVE - 1);

    // key path
    logic [1:0]       key_meta;
    logic             key_sync;
    logic             key_stable;
    logic [CNT_W-1:0] db_cnt;
    logic             db_done;
    logic             press;

    // mode selection
    logic             vs_prev;
    logic             frame_start;
    logic [2:0]       mode_next;
    logic [2:0]       mode_cur;
    pattern_t         pat;

    // pixel pipeline
    logic [2:0]       bar;
    logic [23:0]      color;
    logic             hs_q1, vs_q1, de_q1;
    logic [23:0]      color_q1;
    logic             hs_q2, vs_q2, de_q2;
    logic [23:0]      data_q2;

    assign key_sync    = key_meta[1];
    assign db_done     = (key_sync != key_stable) && (db_cnt == DB_LAST);
    assign press       = db_done && !key_sync;
    assign frame_start = (vs_prev != VS_POL) && (rgb.i_rgb_vs == VS_POL);
    assign pat         = pattern_t'(mode_cur);

    // Two-flop synchroniser for the asynchronous push-button.
    always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
        if (!i_rgb_rst_n) begin
            key_meta <= 2'b11;
        end else begin
            key_meta <= {key_meta[0], i_key};
        end
    end

    // Accept a new key level only after it has held for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
        if (!i_rgb_rst_n) begin
            key_stable <= 1'b1;
            db_cnt     <= '0;
        end else if (key_sync == key_stable) begin
            db_cnt <= '0;
        end else if (db_done) begin
            key_stable <= key_sync;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Presses queue into mode_next; mode_cur latches it at each frame start.
    // Same-cycle press and frame start: mode_cur takes the pre-increment value.
    always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
        if (!i_rgb_rst_n) begin
            vs_prev   <= ~VS_POL;
            mode_next <= INIT_MODE;
            mode_cur  <= INIT_MODE;
        end else begin
            vs_prev <= rgb.i_rgb_vs;
            if (press) begin
                mode_next <= mode_next + 3'd1;
            end
            if (frame_start) begin
                mode_cur <= mode_next;
            end
        end
    end

    // Bar index from a comparator chain against multiples of the bar width.
    always_comb begin
        bar = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (32'(rgb.i_rgb_x) >= k * BAR_W) begin
                bar = 3'(k);
            end
        end
    end

    // Pattern colour for the current input pixel.
    always_comb begin
        color = '0;
        unique case (pat)
            PAT_BARS: begin
                unique case (bar)
                    3'd0: color = 24'hFFFFFF;
                    3'd1: color = 24'hFFFF00;
                    3'd2: color = 24'h00FFFF;
                    3'd3: color = 24'h00FF00;
                    3'd4: color = 24'hFF00FF;
                    3'd5: color = 24'hFF0000;
                    3'd6: color = 24'h0000FF;
                    3'd7: color = 24'h000000;
                endcase
            end
            PAT_GRAY:    color = {3{rgb.i_rgb_x[7:0]}};
            PAT_CHECKER: color = (rgb.i_rgb_x[CHECKER_SHIFT] ^ rgb.i_rgb_y[CHECKER_SHIFT]) ? '1 : '0;
            PAT_RED:     color = 24'hFF0000;
            PAT_GREEN:   color = 24'h00FF00;
            PAT_BLUE:    color = 24'h0000FF;
            PAT_WHITE:   color = 24'hFFFFFF;
            PAT_BORDER:  color = (rgb.i_rgb_x == '0 || rgb.i_rgb_x == X_LAST ||
                                  rgb.i_rgb_y == '0 || rgb.i_rgb_y == Y_LAST) ? '1 : '0;
        endcase
    end

    // Stage 1: register timing and the computed colour.
    always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
        if (!i_rgb_rst_n) begin
            hs_q1    <= 1'b0;
            vs_q1    <= 1'b0;
            de_q1    <= 1'b0;
            color_q1 <= '0;
        end else begin
            hs_q1    <= rgb.i_rgb_hs;
            vs_q1    <= rgb.i_rgb_vs;
            de_q1    <= rgb.i_rgb_de;
            color_q1 <= color;
        end
    end

    // Stage 2: output registers; data is blanked outside the active area.
    always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
        if (!i_rgb_rst_n) begin
            hs_q2   <= 1'b0;
            vs_q2   <= 1'b0;
            de_q2   <= 1'b0;
            data_q2 <= '0;
        end else begin
            hs_q2   <= hs_q1;
            vs_q2   <= vs_q1;
            de_q2   <= de_q1;
            data_q2 <= de_q1 ? color_q1 : '0;
        end
    end

    assign rgb.o_rgb_hs   = hs_q2;
    assign rgb.o_rgb_vs   = vs_q2;
    assign rgb.o_rgb_de   = de_q2;
    assign rgb.o_rgb_data = data_q2;
    assign o_mode         = mode_cur;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen: bars line, key debounce, frame-synchronous
// mode change, border/checker points and asynchronous mid-line reset.
module tb_lcd_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key;
    logic [2:0] mode;

    always #5 clk = ~clk;

    lcd_pattern_gen_if bus();

    lcd_pattern_gen #(
        .DEBOUNCE_CYCLES(16),
        .CNT_W(5)
    ) dut (
        .i_rgb_clk  (clk),
        .i_rgb_rst_n(rst_n),
        .i_key      (key),
        .rgb        (bus),
        .o_mode     (mode)
    );

    int          tests = 0;
    int          fails = 0;
    int          cur_mode;
    logic [26:0] p1, p2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_pix(input int m, input int x, input int y);
        logic [10:0] xv;
        int b;
        xv = 11'(x);
        case (m)
            0: begin
                b = x / 100;
                if (b > 7) b = 7;
                case (b)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return {xv[7:0], xv[7:0], xv[7:0]};
            2: return (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            3: return 24'hFF0000;
            4: return 24'h00FF00;
            5: return 24'h0000FF;
            6: return 24'hFFFFFF;
            default: return (x == 0 || x == 799 || y == 0 || y == 479) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel clock and compare outputs with inputs from two clocks back.
    task automatic cyc(input string tag, input logic h, input logic v, input logic d,
                       input int x, input int y);
        logic [23:0] c;
        bus.i_rgb_hs = h;
        bus.i_rgb_vs = v;
        bus.i_rgb_de = d;
        bus.i_rgb_x  = 11'(x);
        bus.i_rgb_y  = 11'(y);
        c = d ? ref_pix(cur_mode, x, y) : 24'h0;
        tick();
        p2 = p1;
        p1 = {h, v, d, c};
        check(tag, {5'b0, bus.o_rgb_hs, bus.o_rgb_vs, bus.o_rgb_de, bus.o_rgb_data}, {5'b0, p2});
    endtask

    task automatic idle(input int n);
        repeat (n) cyc("idle", 1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic frame();
        cyc("vs", 1'b1, 1'b1, 1'b0, 0, 0);
        repeat (3) cyc("vs", 1'b1, 1'b0, 1'b0, 0, 0);
        repeat (2) cyc("vs", 1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic line(input string tag, input int y, input int x0, input int x1);
        repeat (4) cyc("hs", 1'b0, 1'b1, 1'b0, 0, 0);
        repeat (4) cyc("hs", 1'b1, 1'b1, 1'b0, 0, 0);
        for (int x = x0; x <= x1; x++) cyc(tag, 1'b1, 1'b1, 1'b1, x, y);
        idle(4);
    endtask

    task automatic press(input int nlow);
        key = 1'b0;
        idle(nlow);
        key = 1'b1;
        idle(40);
    endtask

    initial begin
        rst_n        = 1'b0;
        key          = 1'b1;
        bus.i_rgb_hs = 1'b1;
        bus.i_rgb_vs = 1'b1;
        bus.i_rgb_de = 1'b0;
        bus.i_rgb_x  = '0;
        bus.i_rgb_y  = '0;
        p1           = '0;
        p2           = '0;
        cur_mode     = 0;

        // reset state
        repeat (3) tick();
        check("rst_out", {5'b0, bus.o_rgb_hs, bus.o_rgb_vs, bus.o_rgb_de, bus.o_rgb_data}, 32'h0);
        check("rst_mode", {29'b0, mode}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // colour bars across a full active line
        frame();
        check("mode_init", {29'b0, mode}, 32'd0);
        line("bars", 0, 0, 799);

        // debounced press applies only at the next frame start
        press(40);
        check("mode_hold", {29'b0, mode}, 32'd0);
        frame();
        check("mode_step", {29'b0, mode}, 32'd1);
        cur_mode = 1;
        line("gray", 10, 195, 205);
        line("gray_wrap", 10, 250, 260);

        // glitches shorter than the debounce window are ignored
        press(10);
        press(15);
        frame();
        check("glitch_f1", {29'b0, mode}, 32'd1);
        frame();
        check("glitch_f2", {29'b0, mode}, 32'd1);

        // 7 presses from 1 reach 0, then 9 presses in one frame wrap to 1
        repeat (7) press(40);
        frame();
        check("mode_to0", {29'b0, mode}, 32'd0);
        cur_mode = 0;
        repeat (9) press(40);
        check("mode_9_hold", {29'b0, mode}, 32'd0);
        frame();
        check("mode_wrap", {29'b0, mode}, 32'd1);
        cur_mode = 1;

        // border pattern
        repeat (6) press(40);
        frame();
        check("mode_7", {29'b0, mode}, 32'd7);
        cur_mode = 7;
        line("border_l", 5, 0, 1);
        line("border_r", 100, 798, 799);
        line("border_b", 479, 399, 401);
        line("border_mid", 240, 400, 400);

        // checkerboard
        repeat (3) press(40);
        frame();
        check("mode_2", {29'b0, mode}, 32'd2);
        cur_mode = 2;
        line("checker_y0", 0, 30, 33);
        line("checker_y32", 32, 31, 33);

        // asynchronous reset mid-line with a pending mode change
        press(40);
        frame();
        check("mode_3", {29'b0, mode}, 32'd3);
        cur_mode = 3;
        press(40);
        repeat (4) cyc("hs", 1'b0, 1'b1, 1'b0, 0, 0);
        for (int x = 0; x < 50; x++) cyc("red", 1'b1, 1'b1, 1'b1, x, 20);
        rst_n = 1'b0;
        #1;
        check("arst_out", {5'b0, bus.o_rgb_hs, bus.o_rgb_vs, bus.o_rgb_de, bus.o_rgb_data}, 32'h0);
        check("arst_mode", {29'b0, mode}, 32'd0);
        bus.i_rgb_x = 11'd50;
        tick();
        check("arst_hold", {5'b0, bus.o_rgb_hs, bus.o_rgb_vs, bus.o_rgb_de, bus.o_rgb_data}, 32'h0);
        rst_n    = 1'b1;
        p1       = '0;
        p2       = '0;
        cur_mode = 0;
        for (int x = 60; x <= 120; x++) cyc("resume", 1'b1, 1'b1, 1'b1, x, 20);
        idle(4);
        frame();
        check("pending_drop", {29'b0, mode}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
